// File: rtl/spi_driver.sv
// spi_driver
//
// SPI master that brings up an RGB565 SPI LCD controller and then fills
// pixels on key presses. After reset it holds the display in hardware reset,
// waits, streams a fixed initialisation sequence and then waits in READY for
// a push-button. Each press streams RAMWR followed by PIXELS copies of one
// fixed colour.
//
// Ports
//   CLK            system clock, rising edge
//   RESET          synchronous active-high reset
//   KEY[3:0]       push-buttons, active-low, asynchronous
//   LED[3:0]       one-hot status: [0] display reset, [1] init, [2] ready, [3] fill
//   cs             SPI chip select, active-low
//   dc             0 = command byte, 1 = data byte
//   mosi           serial data, MSB first
//   sck            SPI clock, mode 0
//   reset_display  display hardware reset, active-low
//
// Main FSM
//   state    | meaning
//   ---------+------------------------------------------------------
//   RST_LOW  | reset_display held low for RST_CYCLES cycles
//   RST_WAIT | reset_display released, wait WAIT_CYCLES cycles
//   INIT     | stream the init ROM, with delays after SWRESET/SLPOUT
//   READY    | idle, waiting for a key press
//   FILL     | stream RAMWR plus PIXELS x {hi, lo} colour bytes
//
// Byte engine FSM
//   state    | meaning
//   ---------+------------------------------------------------------
//   E_IDLE   | cs high, nothing in flight
//   E_SHIFT  | cs low, 16 SCK half-periods of CLK_DIV cycles each
//   E_GAP    | cs high again, CLK_DIV cycles before the next byte

module spi_driver #(
    parameter int CLK_DIV     = 4,
    parameter int RST_CYCLES  = 1000,
    parameter int WAIT_CYCLES = 1000,
    parameter int PIXELS      = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [3:0] LED,
    output logic       cs,
    output logic       dc,
    output logic       mosi,
    output logic       sck,
    output logic       reset_display
);

    localparam int MAX_WAIT   = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_WAIT + 1);
    localparam int DIV_W      = $clog2(CLK_DIV + 1);
    localparam int FILL_BYTES = 2 * PIXELS + 1;
    localparam int FILL_W     = $clog2(FILL_BYTES + 1);

    localparam logic [CNT_W-1:0]  RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [FILL_W-1:0] FILL_LOAD = FILL_W'(FILL_BYTES);
    localparam logic [2:0]        INIT_LEN  = 3'd5;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        INIT,
        READY,
        FILL
    } state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_SHIFT,
        E_GAP
    } eng_state_t;

    // {dc, byte} for each init step
    function automatic logic [8:0] init_rom(input logic [2:0] i);
        case (i)
            3'd0:    init_rom = {1'b0, 8'h01};
            3'd1:    init_rom = {1'b0, 8'h11};
            3'd2:    init_rom = {1'b0, 8'h3A};
            3'd3:    init_rom = {1'b1, 8'h05};
            3'd4:    init_rom = {1'b0, 8'h29};
            default: init_rom = {1'b0, 8'h00};
        endcase
    endfunction

    function automatic logic [3:0] led_of(input state_t s);
        case (s)
            RST_LOW, RST_WAIT: led_of = 4'b0001;
            INIT:              led_of = 4'b0010;
            READY:             led_of = 4'b0100;
            FILL:              led_of = 4'b1000;
            default:           led_of = 4'b0001;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main controller state
    // ------------------------------------------------------------------
    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              pend, pend_next;
    logic [2:0]        idx, idx_next;
    logic [FILL_W-1:0] fill_left, fill_next;
    logic [15:0]       color, color_next;

    logic [3:0]        key_s1, key_s2, key_s3;
    logic [3:0]        press;
    logic [15:0]       press_color;

    // Byte engine handshake
    logic              start;
    logic [7:0]        tx_byte;
    logic              tx_dc;
    logic              eng_ready;
    logic              eng_idle;

    // key_s3 is the previous synchronised value, so a press is a 1->0 step
    assign press = key_s3 & ~key_s2;

    always_comb begin
        press_color = 16'hFFFF;
        if (press[0]) begin
            press_color = 16'hF800;
        end else if (press[1]) begin
            press_color = 16'h07E0;
        end else if (press[2]) begin
            press_color = 16'h001F;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pend_next  = pend;
        idx_next   = idx;
        fill_next  = fill_left;
        color_next = color;
        start      = 1'b0;
        tx_byte    = 8'h00;
        tx_dc      = 1'b0;

        case (state)
            RST_LOW: begin
                if (cnt == '0) begin
                    state_next = RST_WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            RST_WAIT: begin
                if (cnt == '0) begin
                    state_next = INIT;
                    idx_next   = 3'd0;
                    pend_next  = 1'b0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            INIT: begin
                // Post-command delay only counts once the byte has fully left
                // the engine, so the display sees WAIT_CYCLES of idle bus.
                if (pend && !(eng_idle && cnt == '0)) begin
                    if (eng_idle) begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end else begin
                    pend_next = 1'b0;
                    if (idx == INIT_LEN) begin
                        if (eng_idle) begin
                            state_next = READY;
                        end
                    end else if (eng_ready) begin
                        start              = 1'b1;
                        {tx_dc, tx_byte}   = init_rom(idx);
                        idx_next           = idx + 3'd1;
                        if (idx < 3'd2) begin
                            pend_next = 1'b1;
                            cnt_next  = WAIT_LOAD;
                        end
                    end
                end
            end

            READY: begin
                if (|press) begin
                    state_next = FILL;
                    color_next = press_color;
                    fill_next  = FILL_LOAD;
                end
            end

            FILL: begin
                if (fill_left == '0) begin
                    if (eng_idle) begin
                        state_next = READY;
                    end
                end else if (eng_ready) begin
                    start     = 1'b1;
                    fill_next = fill_left - FILL_W'(1);
                    if (fill_left == FILL_LOAD) begin
                        tx_byte = 8'h2C;
                        tx_dc   = 1'b0;
                    end else if (!fill_left[0]) begin
                        // even remaining count -> first byte of a pixel
                        tx_byte = color[15:8];
                        tx_dc   = 1'b1;
                    end else begin
                        tx_byte = color[7:0];
                        tx_dc   = 1'b1;
                    end
                end
            end

            default: begin
                state_next = RST_LOW;
                cnt_next   = RST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= RST_LOW;
            cnt           <= RST_LOAD;
            pend          <= 1'b0;
            idx           <= 3'd0;
            fill_left     <= '0;
            color         <= 16'h0000;
            key_s1        <= 4'hF;
            key_s2        <= 4'hF;
            key_s3        <= 4'hF;
            LED           <= 4'b0001;
            reset_display <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pend          <= pend_next;
            idx           <= idx_next;
            fill_left     <= fill_next;
            color         <= color_next;
            key_s1        <= KEY;
            key_s2        <= key_s1;
            key_s3        <= key_s2;
            LED           <= led_of(state_next);
            reset_display <= (state_next != RST_LOW);
        end
    end

    // ------------------------------------------------------------------
    // Byte engine
    // ------------------------------------------------------------------
    eng_state_t       eng_state, eng_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [3:0]       half_cnt, half_next;
    logic [7:0]       shreg, shreg_next;
    logic             cs_next, sck_next, mosi_next, dc_next;

    assign eng_idle  = (eng_state == E_IDLE);
    // The last gap cycle already counts as ready so bytes run back to back
    // at exactly 17*CLK_DIV cycles per byte.
    assign eng_ready = eng_idle || (eng_state == E_GAP && div_cnt == '0);

    always_comb begin
        eng_next   = eng_state;
        div_next   = div_cnt;
        half_next  = half_cnt;
        shreg_next = shreg;
        cs_next    = cs;
        sck_next   = sck;
        mosi_next  = mosi;
        dc_next    = dc;

        case (eng_state)
            E_SHIFT: begin
                if (div_cnt != '0) begin
                    div_next = div_cnt - DIV_W'(1);
                end else begin
                    div_next  = DIV_LOAD;
                    half_next = half_cnt + 4'd1;
                    if (!half_cnt[0]) begin
                        sck_next = 1'b1;
                    end else begin
                        sck_next = 1'b0;
                        if (half_cnt == 4'd15) begin
                            cs_next   = 1'b1;
                            mosi_next = 1'b0;
                            eng_next  = E_GAP;
                        end else begin
                            mosi_next  = shreg[7];
                            shreg_next = {shreg[6:0], 1'b0};
                        end
                    end
                end
            end

            E_GAP: begin
                if (div_cnt != '0) begin
                    div_next = div_cnt - DIV_W'(1);
                end else begin
                    eng_next = E_IDLE;
                end
            end

            default: begin
            end
        endcase

        if (start) begin
            eng_next   = E_SHIFT;
            cs_next    = 1'b0;
            sck_next   = 1'b0;
            mosi_next  = tx_byte[7];
            dc_next    = tx_dc;
            shreg_next = {tx_byte[6:0], 1'b0};
            div_next   = DIV_LOAD;
            half_next  = 4'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            eng_state <= E_IDLE;
            div_cnt   <= '0;
            half_cnt  <= 4'd0;
            shreg     <= 8'h00;
            cs        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            dc        <= 1'b0;
        end else begin
            eng_state <= eng_next;
            div_cnt   <= div_next;
            half_cnt  <= half_next;
            shreg     <= shreg_next;
            cs        <= cs_next;
            sck       <= sck_next;
            mosi      <= mosi_next;
            dc        <= dc_next;
        end
    end

endmodule

// File: tb/tb_spi_driver.sv
// tb_spi_driver
//
// Directed bench for spi_driver. The main instance runs with CLK_DIV=1 and
// short delays so the whole init/fill flow is quick; a second instance with
// CLK_DIV=3 only goes through init and has its SCK waveform timed.

module tb_spi_driver;

    localparam int RST_C  = 10;
    localparam int WAIT_C = 10;

    logic       CLK;
    logic       RESET;
    logic [3:0] KEY;
    logic [3:0] LED;
    logic       cs, dc, mosi, sck, reset_display;

    logic       reset3;
    logic [3:0] key3;
    logic [3:0] led3;
    logic       cs3, dc3, mosi3, sck3, reset_display3;

    int n_checks = 0;
    int n_errors = 0;

    spi_driver #(
        .CLK_DIV(1), .RST_CYCLES(RST_C), .WAIT_CYCLES(WAIT_C), .PIXELS(2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .KEY(KEY), .LED(LED),
        .cs(cs), .dc(dc), .mosi(mosi), .sck(sck), .reset_display(reset_display)
    );

    spi_driver #(
        .CLK_DIV(3), .RST_CYCLES(4), .WAIT_CYCLES(4), .PIXELS(2)
    ) dut3 (
        .CLK(CLK), .RESET(reset3), .KEY(key3), .LED(led3),
        .cs(cs3), .dc(dc3), .mosi(mosi3), .sck(sck3), .reset_display(reset_display3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Byte decoder for the main instance: {dc, byte} per completed frame
    // ------------------------------------------------------------------
    logic       prev_cs  = 1'b1;
    logic       prev_sck = 1'b0;
    logic       prev_dc  = 1'b0;
    logic [7:0] rx_sh    = 8'h00;
    int         rx_bits  = 0;
    logic       dc_bad   = 1'b0;
    logic [8:0] rxq[$];
    logic [8:0] expq[$];

    always @(negedge CLK) begin
        if (prev_cs && !cs) begin
            rx_bits = 0;
            rx_sh   = 8'h00;
            dc_bad  = 1'b0;
        end
        if (!prev_cs && !cs && dc !== prev_dc) dc_bad = 1'b1;
        if (!cs && sck && !prev_sck) begin
            rx_sh = {rx_sh[6:0], mosi};
            rx_bits++;
        end
        // a frame cut short by RESET is not a byte
        if (!prev_cs && cs && !RESET) begin
            check("bits_per_byte", rx_bits, 8);
            check("dc_stable", dc_bad, 1'b0);
            rxq.push_back({prev_dc, rx_sh});
        end
        prev_cs  = cs;
        prev_sck = sck;
        prev_dc  = dc;
    end

    // ------------------------------------------------------------------
    // SCK timing for the CLK_DIV=3 instance
    // ------------------------------------------------------------------
    logic prev3_cs   = 1'b1;
    logic prev3_sck  = 1'b0;
    logic prev3_mosi = 1'b0;
    int   low3 = 0, high3 = 0, pulses3 = 0, frames3 = 0;

    always @(negedge CLK) begin
        if (prev3_cs && !cs3) begin
            pulses3 = 0;
            low3    = 0;
        end
        if (sck3 && !prev3_sck) begin
            check("d3_sck_low_phase", low3, 3);
            check("d3_mosi_stable", mosi3, prev3_mosi);
            pulses3++;
            high3 = 0;
        end
        if (!sck3 && prev3_sck) begin
            check("d3_sck_high_phase", high3, 3);
            low3 = 0;
        end
        if (sck3) high3++;
        else if (!cs3) low3++;
        if (!prev3_cs && cs3) begin
            check("d3_pulses_per_byte", pulses3, 8);
            frames3++;
        end
        prev3_cs   = cs3;
        prev3_sck  = sck3;
        prev3_mosi = mosi3;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic expect_bytes(input string tag);
        check({tag, "_count"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            check(tag, rxq[i], expq[i]);
        rxq.delete();
        expq.delete();
    endtask

    task automatic wait_led(input logic [3:0] v, input int max_cyc, input string tag);
        int n = 0;
        while (LED !== v && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check(tag, LED, v);
    endtask

    // called on the negedge where RESET has just been dropped
    task automatic measure_reset_phase(input string tag);
        int n   = 0;
        int bad = 0;
        while (!reset_display && n < 100) begin
            if (LED !== 4'b0001) bad++;
            n++;
            @(negedge CLK);
        end
        check({tag, "_low_cycles"}, n, RST_C);
        check({tag, "_led_low"}, bad, 0);
        check({tag, "_led_wait"}, LED, 4'b0001);
    endtask

    task automatic press(input logic [3:0] k, output int lat);
        KEY = k;
        lat = 0;
        @(negedge CLK);
        lat = 1;
        KEY = 4'hF;
        while (cs && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic push_fill(input logic [15:0] c);
        expq.push_back(9'h02C);
        for (int p = 0; p < 2; p++) begin
            expq.push_back({1'b1, c[15:8]});
            expq.push_back({1'b1, c[7:0]});
        end
    endtask

    task automatic push_init();
        expq.push_back(9'h001);
        expq.push_back(9'h011);
        expq.push_back(9'h03A);
        expq.push_back(9'h105);
        expq.push_back(9'h029);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int n;

        RESET  = 1'b1;
        reset3 = 1'b1;
        KEY    = 4'hF;
        key3   = 4'hF;
        repeat (3) @(negedge CLK);

        check("rst_cs", cs, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_dc", dc, 1'b0);
        check("rst_reset_display", reset_display, 1'b0);
        check("rst_led", LED, 4'b0001);

        RESET  = 1'b0;
        reset3 = 1'b0;
        measure_reset_phase("por");

        wait_led(4'b0100, 500, "init_ready");
        push_init();
        expect_bytes("init_bytes");
        check("ready_cs", cs, 1'b1);
        check("ready_sck", sck, 1'b0);

        // all keys at once: KEY[0] wins -> red
        press(4'b0000, lat);
        check("key_latency_red", (lat <= 4), 1'b1);
        check("fill_led_red", LED, 4'b1000);
        wait_led(4'b0100, 300, "red_done");
        push_fill(16'hF800);
        expect_bytes("red_bytes");
        check("after_fill_cs", cs, 1'b1);

        // green fill, with a KEY[2] press during it that must be dropped
        press(4'b1101, lat);
        check("key_latency_green", (lat <= 4), 1'b1);
        repeat (10) @(negedge CLK);
        check("fill_led_green", LED, 4'b1000);
        KEY = 4'b1011;
        @(negedge CLK);
        KEY = 4'hF;
        wait_led(4'b0100, 300, "green_done");
        repeat (40) @(negedge CLK);
        check("ignored_press_led", LED, 4'b0100);
        push_fill(16'h07E0);
        expect_bytes("green_bytes");

        // KEY[2] in READY -> blue
        press(4'b1011, lat);
        check("key_latency_blue", (lat <= 4), 1'b1);
        wait_led(4'b0100, 300, "blue_done");
        push_fill(16'h001F);
        expect_bytes("blue_bytes");

        // KEY[3] alone -> white
        press(4'b0111, lat);
        wait_led(4'b0100, 300, "white_done");
        push_fill(16'hFFFF);
        expect_bytes("white_bytes");

        // reset in the middle of the first init byte
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        rxq.delete();
        n = 0;
        while (cs && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("abort_byte_started", cs, 1'b0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_cs", cs, 1'b1);
        check("abort_sck", sck, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        check("abort_reset_display", reset_display, 1'b0);
        check("abort_led", LED, 4'b0001);
        @(negedge CLK);
        RESET = 1'b0;
        rxq.delete();
        measure_reset_phase("restart");
        wait_led(4'b0100, 500, "restart_ready");
        push_init();
        expect_bytes("restart_bytes");

        check("d3_frames", frames3, 5);
        check("d3_led", led3, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_driver.md
# spi_driver

Standalone SPI master that brings up an RGB565 SPI LCD controller and fills pixels on key presses. After reset it pulses the display hardware reset, sends a fixed initialisation command sequence, then waits for a key press. Each key press streams one fixed colour to display RAM. It sits between the board's push-buttons/LEDs and the display connector.

## Interface
- CLK_DIV, 4: CLK cycles per SCK half-period (≥1).
- RST_CYCLES, 1000: CLK cycles that `reset_display` is held low.
- WAIT_CYCLES, 1000: delay after display reset release, after SWRESET and after SLPOUT.
- PIXELS, 16: pixels written per fill (2 bytes each).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- KEY  in  4  push-buttons, active-low, asynchronous.
- LED  out  4  status: [0] display-reset phase, [1] init busy, [2] ready, [3] fill busy.
- cs  out  1  SPI chip select, active-low.
- dc  out  1  0 = command byte, 1 = data byte.
- mosi  out  1  serial data, MSB first.
- sck  out  1  SPI clock, mode 0 (idles low).
- reset_display  out  1  display hardware reset, active-low.

## Operation
- Main FSM states, in order: RST_LOW → RST_WAIT → INIT → READY ⇄ FILL.
- RST_LOW: `reset_display`=0 for RST_CYCLES cycles.
- RST_WAIT: `reset_display`=1, wait WAIT_CYCLES cycles.
- INIT: send this ROM sequence:
  - cmd 0x01 (SWRESET), wait WAIT_CYCLES;
  - cmd 0x11 (SLPOUT), wait WAIT_CYCLES;
  - cmd 0x3A, data 0x05;
  - cmd 0x29 (DISPON).
  - Then go to READY.
- READY: accept a key press.
  - KEY is synchronised with 2 flops; a press is a 1→0 transition of the synchronised bit.
  - If several keys fall in the same cycle, the lowest index wins.
  - Presses outside READY are ignored, not queued.
- FILL: send cmd 0x2C (RAMWR), then PIXELS × {high byte, low byte} of the colour, dc=1. Then return to READY.
  - Colours: KEY[0]=0xF800, KEY[1]=0x07E0, KEY[2]=0x001F, KEY[3]=0xFFFF.
- LED: exactly one bit high, matching the state group. RST_LOW and RST_WAIT both drive LED[0].
- Byte engine (shared by INIT and FILL):
  - start asserts `cs`=0 and presents `dc` and bit 7 on `mosi` in the same cycle;
  - 8 SCK pulses;
  - `mosi` updates on each SCK falling edge, so it is stable at each rising edge.

## Timing
- Reset values (cycle after RESET sampled high):
  - cs=1, sck=0, mosi=0, dc=0, reset_display=0, LED=4'b0001;
  - FSM in RST_LOW, key synchronisers = 4'b1111.
- RESET asserted mid-transfer aborts immediately with the values above; no partial-byte completion.
- Byte frame, t=0 is the cs-fall cycle:
  - SCK rises at t = CLK_DIV·(2k+1) and falls at t = CLK_DIV·(2k+2), k = 0..7;
  - `mosi` = bit 7−k from t = 2k·CLK_DIV;
  - cs returns high at t = 16·CLK_DIV, then stays high ≥CLK_DIV cycles before the next byte.
  - Byte period = 17·CLK_DIV cycles.
- `dc` is constant while cs=0 and changes only while cs=1.
- Key-to-first cs fall latency ≤4 CLK cycles (2 sync + edge + start).
- `reset_display` rises exactly RST_CYCLES cycles after reset release.
- Later, `reset_display` stays 1 until the next RESET.

## Test plan
- Reset with CLK_DIV=1, RST_CYCLES=10, WAIT_CYCLES=10, PIXELS=2 → all outputs at their reset values; reset_display=0 for exactly 10 cycles then 1; LED=0001 throughout the reset phase.
- Init sequence → decoded bytes (dc,value) = (0,01),(0,11),(0,3A),(1,05),(0,29); then LED=0100, cs=1, sck=0.
- Pulse KEY=4'b0000 for 1 cycle while in READY → KEY[0] wins; bytes (0,2C),(1,F8),(1,00),(1,F8),(1,00); LED=1000 during the fill, 0100 after.
- KEY[2] pressed during a fill → ignored, no extra bytes; a later KEY[2] press in READY → (0,2C),(1,00),(1,1F)×2.
- RESET asserted mid-byte during INIT → next cycle cs=1, sck=0, reset_display=0; full sequence restarts from RST_LOW.
- SCK check with CLK_DIV=3 → high/low phases exactly 3 cycles; mosi stable at every rising edge; 8 pulses per cs-low window.
